// File: rtl/ntt_r8_sched.sv
// Radix-8 NTT pass sequencer: streams 8-point groups from coefficient RAM into the
// butterfly core and writes results back. Optional NTT_SCHED_BITREV_EN digit-reverses final-stage writes.

module ntt_r8_lane #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_en,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     q <= '0;
        else if (ld_en) q <= ld_data;
    end
endmodule

module ntt_r8_sched #(
    parameter int WIDTH    = 18,
    parameter int N_LOG2   = 6,
    parameter int CORE_LAT = 0,
    localparam int STAGES  = N_LOG2 / 3,
    localparam int GROUPS  = (1 << N_LOG2) / 8,
    localparam int TW_W    = (N_LOG2 - 3 > 1) ? N_LOG2 - 3 : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               mem_rd_en,
    output logic [N_LOG2-1:0]  mem_rd_addr,
    input  logic [WIDTH-1:0]   mem_rd_data,
    output logic               mem_wr_en,
    output logic [N_LOG2-1:0]  mem_wr_addr,
    output logic [WIDTH-1:0]   mem_wr_data,
    output logic [8*WIDTH-1:0] core_in,
    input  logic [8*WIDTH-1:0] core_out,
    output logic [1:0]         stage,
    output logic [TW_W-1:0]    tw_addr
);
    localparam int CNT_MAX = (CORE_LAT + 1 > 8) ? CORE_LAT + 1 : 8;
    localparam int CW      = $clog2(CNT_MAX);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, COMPUTE, STORE, DONE} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [1:0]              s_q;
    logic [TW_W-1:0]         g_q;
    logic [7:0][WIDTH-1:0]   buf_q;
    logic [7:0][WIDTH-1:0]   lane_d;
    logic [7:0]              lane_we;
    logic                    cap_one, cap_all, last_g, last_s;
    logic [2:0]              cap_idx;

    function automatic logic [N_LOG2-1:0] elem_addr(input logic [1:0] s, input logic [TW_W-1:0] g,
                                                    input logic [2:0] k);
        int sh, span, blk, off;
        sh   = 3 * int'(s);
        span = 1 << sh;
        blk  = int'(g) >> sh;
        off  = int'(g) & (span - 1);
        return N_LOG2'((blk << (sh + 3)) + off + (int'(k) << sh));
    endfunction

    function automatic logic [TW_W-1:0] tw_f(input logic [1:0] s, input logic [TW_W-1:0] g);
        int sh;
        sh = 3 * int'(s);
        return TW_W'((int'(g) & ((1 << sh) - 1)) << (3 * (STAGES - 1 - int'(s))));
    endfunction

`ifdef NTT_SCHED_BITREV_EN
    function automatic logic [N_LOG2-1:0] drev(input logic [N_LOG2-1:0] a);
        logic [N_LOG2-1:0] r;
        r = '0;
        for (int i = 0; i < STAGES; i++) r[3*i +: 3] = a[3*(STAGES-1-i) +: 3];
        return r;
    endfunction
`endif

    function automatic logic [N_LOG2-1:0] wr_addr_f(input logic [1:0] s, input logic [TW_W-1:0] g,
                                                    input logic [2:0] k);
`ifdef NTT_SCHED_BITREV_EN
        if (int'(s) == STAGES - 1) return drev(elem_addr(s, g, k));
`endif
        return elem_addr(s, g, k);
    endfunction

    // Read data lags the strobe by one cycle, so LOAD cycle k captures element k-1 and WAIT takes element 7.
    assign cap_one = (state == LOAD && cnt != '0) || state == WAIT;
    assign cap_idx = (state == WAIT) ? 3'd7 : cnt[2:0] - 3'd1;
    assign cap_all = (state == COMPUTE) && (cnt == CW'(CORE_LAT));
    assign last_g  = (g_q == TW_W'(GROUPS - 1));
    assign last_s  = (int'(s_q) == STAGES - 1);

    for (genvar k = 0; k < 8; k++) begin : g_lane
        assign lane_we[k] = cap_all | (cap_one & (cap_idx == 3'(k)));
        assign lane_d[k]  = cap_all ? core_out[k*WIDTH +: WIDTH] : mem_rd_data;
        ntt_r8_lane #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .ld_en   (lane_we[k]),
            .ld_data (lane_d[k]),
            .q       (buf_q[k])
        );
    end

    assign core_in = buf_q;
    assign stage   = s_q;
    assign tw_addr = tw_f(s_q, g_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            s_q         <= '0;
            g_q         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state       <= LOAD;
                    cnt         <= '0;
                    s_q         <= '0;
                    g_q         <= '0;
                    busy        <= 1'b1;
                    mem_rd_en   <= 1'b1;
                    mem_rd_addr <= elem_addr(2'd0, TW_W'(0), 3'd0);
                end
                LOAD: if (cnt == CW'(7)) begin
                    state     <= WAIT;
                    cnt       <= '0;
                    mem_rd_en <= 1'b0;
                end else begin
                    cnt         <= cnt + CW'(1);
                    mem_rd_addr <= elem_addr(s_q, g_q, cnt[2:0] + 3'd1);
                end
                WAIT: begin
                    state <= COMPUTE;
                    cnt   <= '0;
                end
                // Element 0 comes straight from core_out since buf_q updates on this same edge.
                COMPUTE: if (cnt == CW'(CORE_LAT)) begin
                    state       <= STORE;
                    cnt         <= '0;
                    mem_wr_en   <= 1'b1;
                    mem_wr_addr <= wr_addr_f(s_q, g_q, 3'd0);
                    mem_wr_data <= core_out[0 +: WIDTH];
                end else begin
                    cnt <= cnt + CW'(1);
                end
                STORE: if (cnt == CW'(7)) begin
                    cnt       <= '0;
                    mem_wr_en <= 1'b0;
                    if (!last_g) begin
                        g_q         <= g_q + TW_W'(1);
                        state       <= LOAD;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= elem_addr(s_q, g_q + TW_W'(1), 3'd0);
                    end else if (!last_s) begin
                        s_q         <= s_q + 2'd1;
                        g_q         <= '0;
                        state       <= LOAD;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= elem_addr(s_q + 2'd1, TW_W'(0), 3'd0);
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end else begin
                    cnt         <= cnt + CW'(1);
                    mem_wr_addr <= wr_addr_f(s_q, g_q, cnt[2:0] + 3'd1);
                    mem_wr_data <= buf_q[cnt[2:0] + 3'd1];
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
